// File: rtl/sensor_request_arbiter_pkg.sv
// Shared channel indices, FSM encoding and round-robin helpers for the sensor request arbiter.
package sensor_request_arbiter_pkg;

  localparam int NUM_CH = 3;
  localparam int CH_NS  = 0;
  localparam int CH_PED = 1;
  localparam int CH_EW  = 2;

  typedef logic [NUM_CH-1:0] ch_vec_t;
  typedef logic [1:0]        ch_idx_t;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_t;

  // Pick the first requesting channel strictly after ptr, wrapping NS -> PED -> EW -> NS.
  function automatic ch_vec_t rr_pick(input ch_vec_t req, input ch_idx_t ptr);
    ch_vec_t pick;
    logic    found;
    int      idx;
    pick  = '0;
    found = 1'b0;
    for (int k = 1; k <= NUM_CH; k++) begin
      idx = (int'(ptr) + k) % NUM_CH;
      if (!found && req[idx]) begin
        pick[idx] = 1'b1;
        found     = 1'b1;
      end
    end
    return pick;
  endfunction

  function automatic ch_idx_t onehot_to_idx(input ch_vec_t vec);
    ch_idx_t idx;
    idx = ch_idx_t'(CH_NS);
    if (vec[CH_PED]) idx = ch_idx_t'(CH_PED);
    if (vec[CH_EW])  idx = ch_idx_t'(CH_EW);
    return idx;
  endfunction

endpackage

// File: rtl/sensor_request_arbiter_if.sv
// Sensor/controller-facing bus of the arbiter; master drives sensors and served, slave is the arbiter.
interface sensor_request_arbiter_if;
  import sensor_request_arbiter_pkg::*;

  logic    car_ns;
  logic    car_ew;
  logic    ped;
  ch_vec_t served;
  ch_vec_t pending;
  ch_vec_t grant;
  logic    grant_valid;
  logic    starve;

  modport master (
    output car_ns, car_ew, ped, served,
    input  pending, grant, grant_valid, starve
  );

  modport slave (
    input  car_ns, car_ew, ped, served,
    output pending, grant, grant_valid, starve
  );

endinterface

// File: rtl/sensor_request_arbiter_persist_filter.sv
// Two-flop synchronizer followed by a saturating persistence counter for one raw sensor level.
module persist_filter #(
  parameter int PERSIST = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic filtered
);

  localparam int CNT_W = $clog2(PERSIST + 1);

  logic             sync_p0;
  logic             sync_p1;
  logic [CNT_W-1:0] cnt_p2;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      cnt_p2  <= '0;
    end else begin
      // stage p0/p1: metastability guard
      sync_p0 <= raw;
      sync_p1 <= sync_p0;
      // stage p2: persistence count of consecutive synchronized-high cycles
      if (!sync_p1)
        cnt_p2 <= '0;
      else if (cnt_p2 != CNT_W'(PERSIST))
        cnt_p2 <= cnt_p2 + 1'b1;
    end
  end

  // Gating with sync_p1 makes a dropped level stop the request immediately.
  assign filtered = sync_p1 && (cnt_p2 == CNT_W'(PERSIST));

endmodule

// File: rtl/sensor_request_arbiter.sv
// Sensor request arbiter: filters sensors, latches pending requests, grants one phase round-robin.
// Optional starvation override enabled by defining SENSOR_REQ_STARVE_EN.
module sensor_request_arbiter
  import sensor_request_arbiter_pkg::*;
#(
  parameter int PERSIST      = 2,
  parameter int WAIT_W       = 4,
  parameter int STARVE_LIMIT = 10
) (
  input logic clk,
  input logic rst,
  sensor_request_arbiter_if.slave bus
);

`ifdef SENSOR_REQ_STARVE_EN
  localparam logic STARVE_EN = 1'b1;
`else
  localparam logic STARVE_EN = 1'b0;
`endif

  ch_vec_t           raw;
  ch_vec_t           filtered;
  ch_vec_t           pending_q;
  ch_vec_t           granted;
  ch_vec_t           starved;
  ch_vec_t           pick;
  logic              use_starve;
  logic [WAIT_W-1:0] wait_q [NUM_CH];

  arb_state_t state_q, state_d;
  ch_vec_t    grant_q, grant_d;
  logic       starve_q, starve_d;
  ch_idx_t    ptr_q, ptr_d;

  assign raw = {bus.car_ew, bus.ped, bus.car_ns};

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    persist_filter #(.PERSIST(PERSIST)) u_filt (
      .clk      (clk),
      .rst      (rst),
      .raw      (raw[i]),
      .filtered (filtered[i])
    );
  end

  // Clear beats set so a served request re-arms only on the following edge.
  always_ff @(posedge clk) begin
    if (rst)
      pending_q <= '0;
    else
      pending_q <= (pending_q | filtered) & ~bus.served;
  end

  assign granted = (state_q == ST_GRANT) ? grant_q : '0;

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_CH; i++) begin
      if (rst || !pending_q[i])
        wait_q[i] <= '0;
      else if (!granted[i] && (wait_q[i] != '1))
        wait_q[i] <= wait_q[i] + 1'b1;
    end
  end

  always_comb begin
    starved = '0;
    for (int i = 0; i < NUM_CH; i++)
      starved[i] = pending_q[i] && (wait_q[i] >= WAIT_W'(STARVE_LIMIT));
  end

  assign use_starve = STARVE_EN && (|starved);
  assign pick       = rr_pick(use_starve ? starved : pending_q, ptr_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      grant_q  <= '0;
      starve_q <= 1'b0;
      ptr_q    <= ch_idx_t'(CH_EW);
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      starve_q <= starve_d;
      ptr_q    <= ptr_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    starve_d = starve_q;
    ptr_d    = ptr_q;
    case (state_q)
      ST_IDLE: begin
        if (|pending_q) begin
          grant_d  = pick;
          starve_d = use_starve;
          state_d  = ST_GRANT;
        end
      end
      ST_GRANT: begin
        if (|(bus.served & grant_q)) begin
          ptr_d   = onehot_to_idx(grant_q);
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.pending     = pending_q;
  assign bus.grant_valid = (state_q == ST_GRANT);
  assign bus.grant       = granted;
  assign bus.starve      = (state_q == ST_GRANT) && starve_q;

endmodule

// File: tb/tb_sensor_request_arbiter.sv
// Directed bench for sensor_request_arbiter; expectations are hand-computed edge by edge.
module tb_sensor_request_arbiter;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_bad = 0;

  sensor_request_arbiter_if bus ();

  sensor_request_arbiter #(
    .PERSIST      (2),
    .WAIT_W       (4),
    .STARVE_LIMIT (10)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic ns, input logic p, input logic ew);
    bus.car_ns = ns;
    bus.ped    = p;
    bus.car_ew = ew;
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    set_in(1'b0, 1'b0, 1'b0);
    bus.served = 3'b000;
    tick(2);
    rst = 1'b0;
  endtask

  logic [2:0] exp_seq [4] = '{3'b001, 3'b010, 3'b100, 3'b001};
  logic       seen;
  logic       exp_starve;

  initial begin
`ifdef SENSOR_REQ_STARVE_EN
    exp_starve = 1'b1;
`else
    exp_starve = 1'b0;
`endif
    rst        = 1'b1;
    set_in(1'b1, 1'b1, 1'b1);
    bus.served = 3'b000;
    tick(3);
    chk("rst_pending", bus.pending, 3'b000);
    chk("rst_valid", bus.grant_valid, 1'b0);
    chk("rst_grant", bus.grant, 3'b000);
    chk("rst_starve", bus.starve, 1'b0);

    // Single NS request: pending after edge 4, grant after edge 5
    do_reset();
    set_in(1'b1, 1'b0, 1'b0);
    tick(4);
    chk("ns_pend_e3", bus.pending, 3'b000);
    tick();
    chk("ns_pend_e4", bus.pending, 3'b001);
    chk("ns_valid_e4", bus.grant_valid, 1'b0);
    tick();
    chk("ns_grant_e5", bus.grant, 3'b001);
    chk("ns_valid_e5", bus.grant_valid, 1'b1);
    chk("ns_starve_e5", bus.starve, 1'b0);
    set_in(1'b0, 1'b0, 1'b0);
    bus.served = 3'b001;
    tick();
    bus.served = 3'b000;
    chk("ns_served_valid", bus.grant_valid, 1'b0);

    // All three requesting, serve each grant: NS, PED, EW, NS with one idle cycle
    do_reset();
    set_in(1'b1, 1'b1, 1'b1);
    tick(6);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("rr_grant%0d", i), bus.grant, exp_seq[i]);
      chk($sformatf("rr_valid%0d", i), bus.grant_valid, 1'b1);
      chk($sformatf("rr_starve%0d", i), bus.starve, 1'b0);
      bus.served = bus.grant;
      tick();
      bus.served = 3'b000;
      chk($sformatf("rr_idle%0d", i), bus.grant_valid, 1'b0);
      tick();
    end

    // Short ped pulse never latches
    do_reset();
    set_in(1'b0, 1'b1, 1'b0);
    tick(2);
    set_in(1'b0, 1'b0, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      seen = seen | (|bus.pending) | bus.grant_valid;
    end
    chk("short_pulse", seen, 1'b0);

    // NS held for 12 cycles while PED and EW wait
    do_reset();
    set_in(1'b1, 1'b1, 1'b1);
    tick(6);
    chk("stv_first", bus.grant, 3'b001);
    tick(12);
    chk("stv_hold", bus.grant, 3'b001);
    bus.served = 3'b001;
    tick();
    bus.served = 3'b000;
    chk("stv_idle", bus.grant_valid, 1'b0);
    tick();
    chk("stv_grant", bus.grant, 3'b010);
    chk("stv_flag", bus.starve, exp_starve);

    // Served for a non-granted channel only clears its pending bit
    do_reset();
    set_in(1'b1, 1'b1, 1'b1);
    tick(6);
    bus.served = 3'b100;
    tick();
    chk("ng_pending", bus.pending, 3'b011);
    chk("ng_grant", bus.grant, 3'b001);
    chk("ng_valid", bus.grant_valid, 1'b1);
    bus.served = 3'b101;
    tick();
    bus.served = 3'b000;
    chk("multi_pending", bus.pending, 3'b010);
    chk("multi_valid", bus.grant_valid, 1'b0);

    // Reset during GRANT drops everything on the next edge
    do_reset();
    set_in(1'b1, 1'b1, 1'b1);
    tick(6);
    chk("mid_pre_valid", bus.grant_valid, 1'b1);
    rst = 1'b1;
    tick();
    chk("mid_valid", bus.grant_valid, 1'b0);
    chk("mid_grant", bus.grant, 3'b000);
    chk("mid_pending", bus.pending, 3'b000);
    chk("mid_starve", bus.starve, 1'b0);
    rst = 1'b0;
    tick(5);
    chk("post_valid_e4", bus.grant_valid, 1'b0);
    tick();
    chk("post_grant_e5", bus.grant, 3'b001);
    chk("post_valid_e5", bus.grant_valid, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
